// File: rtl/dispatch_unit.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_unit
// Purpose  : Programmable instruction dispatcher for the reservation-station
//            issue bundle. It stores a small instruction program, decodes
//            each word, and issues up to two instructions per cycle. Issue
//            is throttled by the free-slot count that the station reports.
// Options  : DISPATCH_RAW_SPLIT_EN - withholds lane 1 when it reads the
//            destination register that lane 0 writes in the same bundle.
// Revision : 1.0 - initial release
// ============================================================================
module dispatch_unit #(
  parameter int SIZE       = 32,
  parameter int REG_NUM    = 8,
  parameter int ALUOP_BITS = 3,
  parameter int INPUT_ROWS = 2,
  parameter int MEM_ROWS   = 64,
  parameter int IMM_BITS   = 16,
  parameter int RB         = $clog2(REG_NUM),
  parameter int AB         = $clog2(MEM_ROWS),
  parameter int IW         = ALUOP_BITS + 1 + 3 * RB + IMM_BITS,
  parameter int FSW        = $clog2(INPUT_ROWS + 1)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    prog_we,
  input  logic [AB-1:0]                           prog_addr,
  input  logic [IW-1:0]                           prog_data,
  input  logic [AB:0]                             prog_len,
  input  logic                                    start,
  input  logic [FSW-1:0]                          free_slots,
  output logic [INPUT_ROWS-1:0][ALUOP_BITS-1:0]   new_ALUOp,
  output logic [INPUT_ROWS-1:0][RB-1:0]           new_src_reg1,
  output logic [INPUT_ROWS-1:0][RB-1:0]           new_src_reg2,
  output logic [INPUT_ROWS-1:0][RB-1:0]           new_dest_reg1,
  output logic [INPUT_ROWS-1:0]                   new_use_imm,
  output logic [INPUT_ROWS-1:0][SIZE-1:0]         new_imm,
  output logic [INPUT_ROWS-1:0]                   new_valid,
  output logic                                    busy,
  output logic                                    done
);

  localparam int PW = AB + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [PW-1:0]     r_pc;
  logic [PW-1:0]     r_len;
  logic [IW-1:0]     r_mem [MEM_ROWS];

  logic [INPUT_ROWS-1:0][AB-1:0]         w_addr;
  logic [INPUT_ROWS-1:0][IW-1:0]         w_word;
  logic [INPUT_ROWS-1:0][ALUOP_BITS-1:0] w_op;
  logic [INPUT_ROWS-1:0]                 w_use_imm;
  logic [INPUT_ROWS-1:0][RB-1:0]         w_dest;
  logic [INPUT_ROWS-1:0][RB-1:0]         w_src1;
  logic [INPUT_ROWS-1:0][RB-1:0]         w_src2;
  logic [INPUT_ROWS-1:0][SIZE-1:0]       w_imm;

  logic [PW-1:0]         w_avail;
  logic [1:0]            w_n_fs;
  logic [1:0]            w_n_av;
  logic [1:0]            w_n_raw;
  logic [1:0]            w_n;
  logic [INPUT_ROWS-1:0] w_lane_en;
  logic [PW-1:0]         w_pc_next;

  // Lane 1 reads the word after lane 0. The address may wrap when fewer than
  // two words remain, but lane 1 is never enabled in that case.
  assign w_addr[0] = r_pc[AB-1:0];
  assign w_addr[1] = r_pc[AB-1:0] + AB'(1);

  for (genvar l = 0; l < INPUT_ROWS; l++) begin : g_lane
    assign w_word[l]    = r_mem[w_addr[l]];
    assign w_op[l]      = w_word[l][IW-1 -: ALUOP_BITS];
    assign w_use_imm[l] = w_word[l][IW-1-ALUOP_BITS];
    assign w_dest[l]    = w_word[l][3*RB+IMM_BITS-1 -: RB];
    assign w_src1[l]    = w_word[l][2*RB+IMM_BITS-1 -: RB];
    assign w_src2[l]    = w_word[l][RB+IMM_BITS-1 -: RB];
    assign w_imm[l]     = {{(SIZE-IMM_BITS){w_word[l][IMM_BITS-1]}},
                           w_word[l][IMM_BITS-1:0]};
  end

`ifdef DISPATCH_RAW_SPLIT_EN
  logic w_hazard;
  // Lane 1 depends on lane 0 when it reads lane 0's destination register.
  // src2 counts only when lane 1 does not select the immediate.
  assign w_hazard = (w_src1[1] == w_dest[0]) ||
                    (!w_use_imm[1] && (w_src2[1] == w_dest[0]));
`endif

  // Issue count for this cycle: min(free slots, remaining words, 2).
  always_comb begin
    w_avail = r_len - r_pc;
    w_n_fs  = (free_slots >= FSW'(2)) ? 2'd2 : 2'(free_slots);
    w_n_av  = (w_avail >= PW'(2)) ? 2'd2 : w_avail[1:0];
    w_n_raw = (w_n_fs < w_n_av) ? w_n_fs : w_n_av;
    w_n     = w_n_raw;
`ifdef DISPATCH_RAW_SPLIT_EN
    if ((w_n_raw == 2'd2) && w_hazard) begin
      w_n = 2'd1;
    end
`endif
    w_lane_en = {(w_n >= 2'd2), (w_n >= 2'd1)};
    w_pc_next = r_pc + PW'(w_n);
  end

  // The program can be loaded only while dispatch is stopped. Reset does not
  // clear the contents.
  always_ff @(posedge clk) begin
    if (prog_we && (r_state != S_RUN)) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  // Dispatch sequencer with registered bundle outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_len         <= '0;
      new_valid     <= '0;
      new_ALUOp     <= '0;
      new_use_imm   <= '0;
      new_dest_reg1 <= '0;
      new_src_reg1  <= '0;
      new_src_reg2  <= '0;
      new_imm       <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          for (int l = 0; l < INPUT_ROWS; l++) begin
            new_valid[l]     <= w_lane_en[l];
            new_ALUOp[l]     <= w_lane_en[l] ? w_op[l]      : '0;
            new_use_imm[l]   <= w_lane_en[l] ? w_use_imm[l] : 1'b0;
            new_dest_reg1[l] <= w_lane_en[l] ? w_dest[l]    : '0;
            new_src_reg1[l]  <= w_lane_en[l] ? w_src1[l]    : '0;
            new_src_reg2[l]  <= w_lane_en[l] ? w_src2[l]    : '0;
            new_imm[l]       <= w_lane_en[l] ? w_imm[l]     : '0;
          end
          r_pc <= w_pc_next;
          if (w_pc_next == r_len) begin
            r_state <= S_DONE;
          end
        end
        default: begin
          new_valid     <= '0;
          new_ALUOp     <= '0;
          new_use_imm   <= '0;
          new_dest_reg1 <= '0;
          new_src_reg1  <= '0;
          new_src_reg2  <= '0;
          new_imm       <= '0;
          if (start) begin
            r_pc    <= '0;
            r_len   <= prog_len;
            r_state <= (prog_len == '0) ? S_DONE : S_RUN;
          end
        end
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_dispatch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_dispatch_unit
// Purpose  : Scoreboard bench for dispatch_unit. The stimulus side predicts
//            each bundle from the program image and pushes it to a queue.
//            The monitor pops the queue and compares each bundle the DUT
//            presents. Honours DISPATCH_RAW_SPLIT_EN the same way as the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dispatch_unit;

  logic              clk = 1'b0;
  logic              rst;
  logic              prog_we;
  logic [5:0]        prog_addr;
  logic [28:0]       prog_data;
  logic [6:0]        prog_len;
  logic              start;
  logic [1:0]        free_slots;
  logic [1:0][2:0]   new_ALUOp;
  logic [1:0][2:0]   new_src_reg1;
  logic [1:0][2:0]   new_src_reg2;
  logic [1:0][2:0]   new_dest_reg1;
  logic [1:0]        new_use_imm;
  logic [1:0][31:0]  new_imm;
  logic [1:0]        new_valid;
  logic              busy;
  logic              done;

  dispatch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .prog_len     (prog_len),
    .start        (start),
    .free_slots   (free_slots),
    .new_ALUOp    (new_ALUOp),
    .new_src_reg1 (new_src_reg1),
    .new_src_reg2 (new_src_reg2),
    .new_dest_reg1(new_dest_reg1),
    .new_use_imm  (new_use_imm),
    .new_imm      (new_imm),
    .new_valid    (new_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       v;
    logic [1:0][2:0]  op;
    logic [1:0]       ui;
    logic [1:0][2:0]  d;
    logic [1:0][2:0]  s1;
    logic [1:0][2:0]  s2;
    logic [1:0][31:0] imm;
    logic             dn;
  } bundle_t;

  bundle_t     sb[$];
  int          fs_q[$];
  logic [1:0]  obs_v[$];
  logic [28:0] mdl_mem [64];
  logic [31:0] last_imm0;
  logic        last_ui0;
  int          nchk = 0;
  int          nerr = 0;

  // Monitor: each bundle the DUT presents is checked against the next
  // predicted bundle.
  always @(negedge clk) begin
    bundle_t a;
    bundle_t e;
    if (new_valid != 2'b00) begin
      a.v = new_valid; a.op = new_ALUOp; a.ui = new_use_imm;
      a.d = new_dest_reg1; a.s1 = new_src_reg1; a.s2 = new_src_reg2;
      a.imm = new_imm; a.dn = done;
      obs_v.push_back(new_valid);
      last_imm0 = new_imm[0];
      last_ui0  = new_use_imm[0];
      nchk++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL bundle_unexpected: got %h, expected no bundle", a);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          nerr++;
          $display("FAIL bundle: got %h expected %h", a, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [28:0] mk(input int op, ui, d, s1, s2, imm);
    return (29'(op & 7) << 26) | (29'(ui & 1) << 25) | (29'(d & 7) << 22) |
           (29'(s1 & 7) << 19) | (29'(s2 & 7) << 16) | 29'(imm & 16'hFFFF);
  endfunction

  // Lane 1 depends on lane 0 when it reads lane 0's destination register.
  function automatic bit dep(input logic [28:0] w0, input logic [28:0] w1);
    int d0, a1, b1, ui1;
    d0 = int'(w0 >> 22) & 7;
    a1 = int'(w1 >> 19) & 7;
    b1 = int'(w1 >> 16) & 7;
    ui1 = int'(w1 >> 25) & 1;
    return (a1 == d0) || (ui1 == 0 && b1 == d0);
  endfunction

  function automatic int model_n(input int pc, input int len, input int fs);
    int n;
    n = fs;
    if (len - pc < n) n = len - pc;
    if (n > 2) n = 2;
`ifdef DISPATCH_RAW_SPLIT_EN
    if (n == 2 && dep(mdl_mem[pc], mdl_mem[pc+1])) n = 1;
`endif
    return n;
  endfunction

  function automatic bundle_t mk_exp(input int pc, input int n, input bit dn);
    bundle_t b;
    logic [28:0] w;
    int imm16;
    b = '0;
    for (int l = 0; l < n; l++) begin
      w = mdl_mem[pc + l];
      b.v[l]  = 1'b1;
      b.op[l] = 3'(w >> 26);
      b.ui[l] = 1'(w >> 25);
      b.d[l]  = 3'(w >> 22);
      b.s1[l] = 3'(w >> 19);
      b.s2[l] = 3'(w >> 16);
      imm16   = int'(w) & 32'hFFFF;
      b.imm[l] = (imm16 >= 32768) ? 32'(imm16 - 65536) : 32'(imm16);
    end
    b.dn = dn;
    return b;
  endfunction

  task automatic write_word(input int addr, input logic [28:0] w);
    prog_we = 1'b1; prog_addr = 6'(addr); prog_data = w;
    mdl_mem[addr] = w;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Start a program and drive free_slots each cycle, predicting bundles.
  // abort_at >= 0 asserts rst in place of that issue decision.
  task automatic run_prog(input int len, input int abort_at, input bit noise,
                          input bit we_start);
    int pc, dec, budget, fs, n;
    logic [28:0] w;
    start = 1'b1; prog_len = 7'(len);
    if (we_start) begin
      w = 29'($urandom);
      prog_we = 1'b1; prog_addr = 6'd0; prog_data = w;
      mdl_mem[0] = w;
    end
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    chk("busy_after_start", 64'(busy), 64'(len != 0));
    chk("done_after_start", 64'(done), 64'(len == 0));
    pc = 0; dec = 0; budget = 0;
    while (pc < len) begin
      if (budget > 400) begin
        chk("run_timeout", 64'(pc), 64'(len));
        break;
      end
      budget++;
      fs = (fs_q.size() > 0) ? fs_q.pop_front() : int'($urandom_range(0, 2));
      free_slots = 2'(fs);
      if (noise) begin
        start = 1'($urandom); prog_we = 1'($urandom);
        prog_addr = 6'($urandom); prog_data = 29'($urandom);
      end
      if (dec == abort_at) begin
        rst = 1'b1; start = 1'b0; prog_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_valid", 64'(new_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_queue", 64'(sb.size()), 64'd0);
        fs_q.delete();
        return;
      end
      n = model_n(pc, len, fs);
      if (n > 0) sb.push_back(mk_exp(pc, n, (pc + n) == len));
      pc += n;
      dec++;
      @(negedge clk);
    end
    start = 1'b0; prog_we = 1'b0; free_slots = 2'd0;
    @(negedge clk);
    chk("end_done", 64'(done), 64'd1);
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_queue", 64'(sb.size()), 64'd0);
    sb.delete();
    fs_q.delete();
  endtask

  initial begin
    int len;
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    prog_len = '0; start = 1'b0; free_slots = '0;
    repeat (3) @(negedge clk);
    chk("reset_valid", 64'(new_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_imm", 64'(new_imm[0]), 64'd0);
    rst = 1'b0;

    // Four words with two free slots held: two full bundles.
    for (int i = 0; i < 8; i++) write_word(i, mk(i, i & 1, i, 7 - i, (i + 2) & 7, 100 * i));
    fs_q = '{2, 2, 2};
    run_prog(4, -1, 0, 0);

    // Three words: a full bundle, then lane 0 only.
    fs_q = '{2, 2};
    run_prog(3, -1, 0, 0);

    // free_slots sequence 2,0,1,2 over five words.
    fs_q = '{2, 0, 1, 2};
    run_prog(5, -1, 0, 0);

    // Negative immediate is sign-extended.
    write_word(0, mk(5, 1, 2, 1, 4, 16'hFFF6));
    fs_q = '{2};
    run_prog(1, -1, 0, 0);
    chk("imm_sext", 64'(last_imm0), 64'hFFFF_FFF6);
    chk("imm_use", 64'(last_ui0), 64'd1);

    // Reset one cycle after the first bundle, then a clean rerun.
    for (int i = 0; i < 8; i++) write_word(i, mk(7 - i, 0, i, i, i, 16'h8000 + i));
    fs_q = '{2, 2, 2, 2};
    run_prog(8, 1, 0, 0);
    fs_q = '{2, 2, 2, 2};
    run_prog(8, -1, 0, 0);

    // Dependent pair: word1 reads word0's destination.
    write_word(0, mk(1, 0, 3, 0, 1, 5));
    write_word(1, mk(2, 1, 4, 3, 6, 7));
    obs_v.delete();
    fs_q = '{2, 2};
    run_prog(2, -1, 0, 0);
`ifdef DISPATCH_RAW_SPLIT_EN
    chk("raw_count", 64'(obs_v.size()), 64'd2);
    if (obs_v.size() == 2) begin
      chk("raw_v0", 64'(obs_v[0]), 64'b01);
      chk("raw_v1", 64'(obs_v[1]), 64'b01);
    end
`else
    chk("raw_count", 64'(obs_v.size()), 64'd1);
    if (obs_v.size() == 1) chk("raw_v0", 64'(obs_v[0]), 64'b11);
`endif

    // Empty program finishes immediately without a bundle.
    run_prog(0, -1, 0, 0);

    // Randomized programs with throttling, ignored writes and ignored starts.
    for (int r = 0; r < 20; r++) begin
      len = (r == 0) ? 64 : int'($urandom_range(1, 64));
      for (int i = 0; i < len; i++) write_word(i, 29'($urandom));
      run_prog(len, -1, 1, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dispatch_unit.md
# dispatch_unit

Instruction dispatcher on the transmit side of the reservation-station issue bundle. Holds a small programmable instruction memory, decodes each word into ALUOp, source/destination register, immediate-select and immediate fields, and drives up to INPUT_ROWS instructions per cycle with per-lane `new_valid`. Issue is throttled by the station's reported free-slot count. The block replaces hand-driven stimulus on the station's `new_*` inputs.

## Interface
- SIZE, 32, data/immediate width after sign extension
- REG_NUM, 8, architectural registers; RB = $clog2(REG_NUM)
- ALUOP_BITS, 3, ALU opcode width
- INPUT_ROWS, 2, issue lanes; fixed at 2 for this block
- MEM_ROWS, 64, instruction memory depth; AB = $clog2(MEM_ROWS)
- IMM_BITS, 16, encoded immediate width
- Instruction word width IW = ALUOP_BITS+1+3*RB+IMM_BITS, MSB→LSB: ALUOp, use_imm, dest, src1, src2, imm

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- prog_we  in  1  write strobe for instruction memory
- prog_addr  in  AB  write address
- prog_data  in  IW  instruction word
- prog_len  in  AB+1  instruction count, 0..MEM_ROWS, sampled on start
- start  in  1  begin dispatch at address 0
- free_slots  in  $clog2(INPUT_ROWS+1)  station free entries, saturated at INPUT_ROWS
- new_ALUOp  out  [INPUT_ROWS][ALUOP_BITS]  per-lane opcode
- new_src_reg1, new_src_reg2, new_dest_reg1  out  [INPUT_ROWS][RB]  register indices
- new_use_imm  out  [INPUT_ROWS]  immediate select
- new_imm  out  [INPUT_ROWS][SIZE]  sign-extended immediate
- new_valid  out  [INPUT_ROWS]  lane carries an instruction this cycle
- busy  out  1  state is RUN
- done  out  1  state is DONE

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; pc=0, len=0, all outputs 0.
- IDLE/DONE + start=1 → RUN; pc←0, len←prog_len. If prog_len=0: → DONE directly, nothing issued.
- RUN: n = min(free_slots, len−pc, 2). Lane 0 filled before lane 1; lane 0 gets mem[pc], lane 1 gets mem[pc+1]. new_valid ← {n≥2, n≥1}. pc ← pc+n.
- RUN → DONE on the cycle pc+n = len; DONE holds done=1 until the next start.
- start while RUN ignored.
- Memory writes accepted only in IDLE/DONE; ignored in RUN. Contents not cleared by rst.
- Invalid lanes drive all fields 0. Valid lanes: new_imm = sign-extended imm field; driven regardless of use_imm.
- pc never exceeds len; no wrap past MEM_ROWS−1 since len ≤ MEM_ROWS.

## Timing
- Bundle outputs registered. Issue decision in cycle t uses free_slots at t; bundle visible cycle t+1 for exactly one cycle.
- start asserted cycle t → busy=1 at t+1 → first bundle earliest at t+2.
- done rises the cycle after the final bundle is decided, i.e. concurrently with the final bundle; busy falls the same cycle.
- free_slots=0 in RUN: new_valid=00 next cycle, pc held.
- rst mid-RUN: next cycle state IDLE, new_valid=00, busy=done=0; in-flight bundle discarded.
- prog_we in the same cycle as start (from IDLE): write performed, then start taken.

## Configuration
- DISPATCH_RAW_SPLIT_EN defined: if both lanes would issue and lane-1 src1 or src2 (src2 only when lane-1 use_imm=0) equals lane-0 dest, lane 1 is withheld; n=1 that cycle, lane 1 instruction issues next cycle as lane 0.
- Undefined: no intra-bundle dependency check; dependent pairs issue together.

## Test plan
- Program 4 words, prog_len=4, free_slots=2 held, start → two bundles new_valid=11 on consecutive cycles, lanes in address order; done=1 with second bundle.
- prog_len=3, free_slots=2 → bundles 11 then 01; lane 1 fields 0 on last bundle.
- free_slots sequence 2,0,1,2 with prog_len=5 → new_valid 11,00,01,11; pc ends 5, done=1.
- Word imm=16'hFFF6, use_imm=1 → new_imm=32'hFFFF_FFF6, new_use_imm=1.
- rst one cycle after first bundle of an 8-word program → new_valid=00, busy=0 next cycle; restart reissues from address 0.
- With DISPATCH_RAW_SPLIT_EN: word0 dest=3, word1 src1=3 → new_valid 01 then 01; without macro → 11 in one cycle.
